// File: rtl/descrypt_core_dispatch.sv
// Round-robin dispatcher from the descrypt word generator to the DES crypt cores.
// It tracks busy cores locally and drains all cores before applying a new salt.
module descrypt_core_dispatch #(
    parameter int unsigned N_CORES    = 16,
    parameter int unsigned WORD_WIDTH = 56,
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned SALT_WIDTH = 12
) (
    input  logic                             CORE_CLK,
    input  logic                             rst_n,
    input  logic [WORD_WIDTH-1:0]            word_in,
    input  logic [ID_WIDTH-1:0]              word_id_in,
    input  logic                             word_valid,
    output logic                             word_rd,
    input  logic [SALT_WIDTH-1:0]            salt_in,
    input  logic                             salt_valid,
    output logic                             salt_ready,
    output logic [WORD_WIDTH-1:0]            core_word,
    output logic [ID_WIDTH-1:0]              core_word_id,
    output logic [SALT_WIDTH-1:0]            core_salt,
    output logic [N_CORES-1:0]               core_start,
    input  logic [N_CORES-1:0]               core_done,
    output logic [$clog2(N_CORES+1)-1:0]     cores_busy,
    output logic [31:0]                      words_dispatched,
    output logic                             idle
);

    localparam int unsigned PTR_W = $clog2(N_CORES);
    localparam int unsigned CNT_W = $clog2(N_CORES+1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_e;

    state_e                  state_q, state_d;
    logic [N_CORES-1:0]      busy_q, busy_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [SALT_WIDTH-1:0]   salt_q, salt_d;
    logic [N_CORES-1:0]      start_q, start_d;
    logic [31:0]             count_q, count_d;

    logic                    accept;
    logic                    found;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        idx;
    logic [CNT_W-1:0]        popcnt;

    always_ff @(posedge CORE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (salt_valid) state_d = ST_DRAIN;
            // A salt withdrawn mid-drain still waits for the mask to empty.
            ST_DRAIN: if (busy_q == '0) state_d = salt_valid ? ST_LOAD : ST_RUN;
            ST_LOAD:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        word_rd    = 1'b0;
        salt_ready = 1'b0;
        case (state_q)
            ST_RUN:  word_rd = ~salt_valid & ~(&busy_q);
            ST_LOAD: salt_ready = 1'b1;
            default: ;
        endcase
    end

    assign accept = word_valid & word_rd;

    // Winner search uses the registered mask, so a core freed this cycle waits one cycle.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned off = 1; off <= N_CORES; off++) begin
            idx = PTR_W'((32'(rr_ptr_q) + off) % N_CORES);
            if (!found && !busy_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        busy_d   = busy_q & ~core_done;
        rr_ptr_d = rr_ptr_q;
        word_d   = word_q;
        id_d     = id_q;
        start_d  = '0;
        count_d  = count_q;
        salt_d   = (state_q == ST_LOAD) ? salt_in : salt_q;
        if (accept) begin
            busy_d[winner]  = 1'b1;
            start_d[winner] = 1'b1;
            rr_ptr_d        = winner;
            word_d          = word_in;
            id_d            = word_id_in;
            count_d         = count_q + 32'd1;
        end
    end

    always_ff @(posedge CORE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            rr_ptr_q <= PTR_W'(N_CORES - 1);
            word_q   <= '0;
            id_q     <= '0;
            salt_q   <= '0;
            start_q  <= '0;
            count_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            word_q   <= word_d;
            id_q     <= id_d;
            salt_q   <= salt_d;
            start_q  <= start_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        popcnt = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            popcnt = popcnt + CNT_W'(busy_q[i]);
        end
    end

    assign core_word        = word_q;
    assign core_word_id     = id_q;
    assign core_salt        = salt_q;
    assign core_start       = start_q;
    assign cores_busy       = popcnt;
    assign words_dispatched = count_q;
    assign idle             = (state_q == ST_RUN) && (busy_q == '0) && !word_valid;

endmodule

// File: tb/tb_descrypt_core_dispatch.sv
// Randomized bench for descrypt_core_dispatch (4 cores) against a cycle-level behavioural model.
module tb_descrypt_core_dispatch;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [55:0]   word_in = '0;
    logic [15:0]   word_id_in = '0;
    logic          word_valid = 1'b0;
    logic          word_rd;
    logic [11:0]   salt_in = '0;
    logic          salt_valid = 1'b0;
    logic          salt_ready;
    logic [55:0]   core_word;
    logic [15:0]   core_word_id;
    logic [11:0]   core_salt;
    logic [N-1:0]  core_start;
    logic [N-1:0]  core_done = '0;
    logic [2:0]    cores_busy;
    logic [31:0]   words_dispatched;
    logic          idle;

    descrypt_core_dispatch #(
        .N_CORES(N), .WORD_WIDTH(56), .ID_WIDTH(16), .SALT_WIDTH(12)
    ) dut (
        .CORE_CLK(clk), .rst_n(rst_n),
        .word_in(word_in), .word_id_in(word_id_in), .word_valid(word_valid), .word_rd(word_rd),
        .salt_in(salt_in), .salt_valid(salt_valid), .salt_ready(salt_ready),
        .core_word(core_word), .core_word_id(core_word_id), .core_salt(core_salt),
        .core_start(core_start), .core_done(core_done), .cores_busy(cores_busy),
        .words_dispatched(words_dispatched), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = RUN, 1 = DRAIN, 2 = LOAD
    int          m_state;
    bit          m_busy[N];
    int          m_ptr;
    int          m_start;
    logic [55:0] m_word;
    logic [15:0] m_id;
    logic [11:0] m_salt;
    int unsigned m_cnt;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic bit m_rd(input bit sv);
        return (m_state == 0) && !sv && (m_count() < N);
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_ptr   = N - 1;
        m_start = -1;
        m_word  = '0;
        m_id    = '0;
        m_salt  = '0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input bit wv, input bit sv);
        check("word_rd", 64'(word_rd), 64'(m_rd(sv)));
        check("salt_ready", 64'(salt_ready), 64'(m_state == 2));
        check("core_start", 64'(core_start), (m_start < 0) ? 64'd0 : (64'd1 << m_start));
        check("core_word", 64'(core_word), 64'(m_word));
        check("core_word_id", 64'(core_word_id), 64'(m_id));
        check("core_salt", 64'(core_salt), 64'(m_salt));
        check("cores_busy", 64'(cores_busy), 64'(m_count()));
        check("words_dispatched", 64'(words_dispatched), 64'(m_cnt));
        check("idle", 64'(idle), 64'((m_state == 0) && (m_count() == 0) && !wv));
    endtask

    task automatic model_step(input bit wv, input logic [55:0] w, input logic [15:0] id,
                              input bit sv, input logic [11:0] s, input logic [N-1:0] done);
        bit acc = wv && m_rd(sv);
        int nbusy = m_count();
        int win = -1;
        int nstate = m_state;
        case (m_state)
            0: if (sv) nstate = 1;
            1: if (nbusy == 0) nstate = sv ? 2 : 0;
            default: begin m_salt = s; nstate = 0; end
        endcase
        if (acc) begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_ptr + k) % N;
                if (win < 0 && !m_busy[c]) win = c;
            end
        end
        for (int i = 0; i < N; i++) if (done[i]) m_busy[i] = 0;
        m_start = -1;
        if (acc && win >= 0) begin
            m_busy[win] = 1;
            m_ptr   = win;
            m_start = win;
            m_word  = w;
            m_id    = id;
            m_cnt   = m_cnt + 1;
        end
        m_state = nstate;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit wv, input logic [55:0] w, input logic [15:0] id,
                         input bit sv, input logic [11:0] s, input logic [N-1:0] done);
        word_valid = wv; word_in = w; word_id_in = id;
        salt_valid = sv; salt_in = s; core_done = done;
        #1;
        check_outputs(wv, sv);
        model_step(wv, w, id, sv, s, done);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit sv);
        rst_n = 1'b0;
        word_valid = 1'b1; word_in = 56'h0123_4567_89AB_CD; word_id_in = 16'hBEEF;
        salt_valid = sv; salt_in = 12'hABC; core_done = '1;
        #1;
        model_reset();
        check_outputs(1'b1, sv);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [55:0] rw();
        return 56'({$urandom(), $urandom()});
    endfunction

    initial begin
        bit sv_cur = 0;
        bit hs_last = 0;
        bit hs_done = 0;
        logic [11:0] s_cur = '0;
        logic [N-1:0] dn;

        @(negedge clk);
        do_reset(1'b0);

        for (int k = 0; k < 6; k++) cycle(k < 5, rw(), 16'(k + 1), 1'b0, '0, '0);
        cycle(1'b0, rw(), '0, 1'b0, '0, 4'b1010);
        for (int k = 0; k < 3; k++) cycle(k < 2, rw(), 16'(k + 16'h40), 1'b0, '0, '0);

        cycle(1'b0, rw(), '0, 1'b0, '0, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            bit svl = !hs_done;
            bit hs = svl && (m_state == 2);
            dn = (k < 3) ? (4'b0010 << k) : '0;
            cycle(1'b1, rw(), 16'(k + 16'h80), svl, 12'h1C7, dn);
            if (hs) hs_done = 1;
        end

        for (int it = 0; it < 600; it++) begin
            if (it == 300) begin
                do_reset(1'b1);
                cycle(1'b1, rw(), 16'h5A5A, 1'b0, '0, '0);
                cycle(1'b0, rw(), '0, 1'b0, '0, '0);
                sv_cur = 0;
                hs_last = 0;
            end
            if (hs_last) sv_cur = 0;
            else if (!sv_cur && $urandom_range(0, 29) == 0) begin
                sv_cur = 1;
                s_cur = 12'($urandom());
            end else if (sv_cur && $urandom_range(0, 49) == 0) sv_cur = 0;
            hs_last = sv_cur && (m_state == 2);
            for (int i = 0; i < N; i++)
                dn[i] = m_busy[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
            cycle($urandom_range(0, 3) != 0, rw(), 16'($urandom()), sv_cur, s_cur, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
